// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the ALU command sequencer.
//   - opcode constants understood by the downstream 8-bit ALU
//   - issue FSM state type
//   - divide-by-zero substitute result
//   - command record carried through the command FIFO
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;

  localparam logic [7:0] DIV0_VAL = 8'hFF;

  // Widest tag the command record can carry; the top keeps only TAG_W bits.
  localparam int TAG_MAX_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0]           sel;
    logic [7:0]           a;
    logic [7:0]           b;
    logic [TAG_MAX_W-1:0] tag;
  } cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous FIFO of command records.
// Ports:
//   clock, reset_n   clock, async active-low reset (pointers/count only)
//   push, wdata      write request and record (ignored when full)
//   pop, rdata       read request (ignored when empty) and head record
//   count            occupancy, 0..DEPTH
//   full, empty      occupancy flags
module alu_cmd_fifo
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  cmd_t                     wdata,
  input  logic                     pop,
  output cmd_t                     rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  cmd_t           mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           push_ok;
  logic           pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: queues tagged ALU commands and issues them one at a time
// to an external 8-bit ALU with a registered result, then returns a tagged,
// error-flagged response.
// Ports:
//   clock, reset_n                  clock, async active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_sel, cmd_a, cmd_b, cmd_tag  command opcode, operands, tag
//   alu_a, alu_b, alu_sel           registered ALU operand/opcode drive
//   alu_out, alu_carry              ALU registered result and carry
//   rsp_valid/rsp_ready             response handshake
//   rsp_data, rsp_carry, rsp_err    response payload
//   rsp_tag                         tag of the answered command
//   count                           command FIFO occupancy
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [3:0]             cmd_sel,
  input  logic [7:0]             cmd_a,
  input  logic [7:0]             cmd_b,
  input  logic [TAG_W-1:0]       cmd_tag,
  output logic [7:0]             alu_a,
  output logic [7:0]             alu_b,
  output logic [3:0]             alu_sel,
  input  logic [7:0]             alu_out,
  input  logic                   alu_carry,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [7:0]             rsp_data,
  output logic                   rsp_carry,
  output logic                   rsp_err,
  output logic [TAG_W-1:0]       rsp_tag,
  output logic [$clog2(DEPTH):0] count
);

  cmd_t             wr_cmd;
  cmd_t             head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             slot_free;
  state_t           state;
  logic [3:0]       pend_sel;
  logic [TAG_W-1:0] pend_tag;
  logic [9:0]       rsp_map;

  // Maps the ALU result onto {data, carry, err}. Carry is only meaningful for
  // add; a zero divisor replaces whatever the ALU produced.
  function automatic logic [9:0] map_rsp(input logic [3:0] sel,
                                         input logic [7:0] b,
                                         input logic [7:0] res,
                                         input logic       cy);
    logic [9:0] r;
    case (sel)
      OP_ADD:         r = {res, cy, 1'b0};
      OP_SUB, OP_MUL: r = {res, 1'b0, 1'b0};
      OP_DIV:         r = (b == 8'd0) ? {DIV0_VAL, 1'b0, 1'b1} : {res, 1'b0, 1'b0};
      default:        r = {res, 1'b0, 1'b1};
    endcase
    return r;
  endfunction

  always_comb begin
    wr_cmd     = '0;
    wr_cmd.sel = cmd_sel;
    wr_cmd.a   = cmd_a;
    wr_cmd.b   = cmd_b;
    wr_cmd.tag = TAG_MAX_W'(cmd_tag);
  end

  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  assign slot_free = !rsp_valid || rsp_ready;
  assign pop       = (state == IDLE) && !fifo_empty && slot_free;
  // alu_b still holds the issued divisor during CAPT.
  assign rsp_map   = map_rsp(pend_sel, alu_b, alu_out, alu_carry);

  alu_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (wr_cmd),
    .pop     (pop),
    .rdata   (head),
    .count   (count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      pend_sel  <= '0;
      pend_tag  <= '0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_tag   <= '0;
    end else begin
      case (state)
        // issue: pop head into the ALU operand registers
        IDLE: begin
          if (pop) begin
            alu_a    <= head.a;
            alu_b    <= head.b;
            alu_sel  <= head.sel;
            pend_sel <= head.sel;
            pend_tag <= head.tag[TAG_W-1:0];
            state    <= EXEC;
          end
        end
        // ALU registers its result at the end of this cycle
        EXEC: state <= CAPT;
        // capture: ALU result is valid, load the response slot
        CAPT: begin
          {rsp_data, rsp_carry, rsp_err} <= rsp_map;
          rsp_tag <= pend_tag;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A capture on the same edge as an accept keeps the slot full.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)            rsp_valid <= 1'b0;
    else if (state == CAPT)  rsp_valid <= 1'b1;
    else if (rsp_ready)      rsp_valid <= 1'b0;
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
module tb_alu_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [3:0]       cmd_sel = '0;
  logic [7:0]       cmd_a = '0;
  logic [7:0]       cmd_b = '0;
  logic [TAG_W-1:0] cmd_tag = '0;
  logic [7:0]       alu_a, alu_b;
  logic [3:0]       alu_sel;
  logic [7:0]       alu_out;
  logic             alu_carry;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [7:0]       rsp_data;
  logic             rsp_carry, rsp_err;
  logic [TAG_W-1:0] rsp_tag;
  logic [2:0]       count;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  alu_cmd_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_err(rsp_err), .rsp_tag(rsp_tag),
    .count(count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // External ALU behaviour: registered result; divide by zero yields junk.
  function automatic logic [7:0] alu_fn(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = a * b;
    case (s)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return p[7:0];
      4'd3:  return (b == 0) ? 8'h5A : a / b;
      4'd4:  return a << 1;
      4'd5:  return a >> 1;
      4'd6:  return {a[6:0], a[7]};
      4'd7:  return {a[0], a[7:1]};
      4'd8:  return a & b;
      4'd9:  return a | b;
      4'd10: return a ^ b;
      4'd11: return ~(a | b);
      4'd12: return ~(a & b);
      4'd13: return ~(a ^ b);
      4'd14: return (a > b) ? 8'd1 : 8'd0;
      default: return (a == b) ? 8'd1 : 8'd0;
    endcase
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      alu_out   <= '0;
      alu_carry <= 1'b0;
    end else begin
      alu_out   <= alu_fn(alu_sel, alu_a, alu_b);
      alu_carry <= ((9'(alu_a) + 9'(alu_b)) > 9'd255);
    end
  end

  // Expected response {data, carry, err, tag} from the opcode rules.
  function automatic logic [13:0] ref_rsp(input logic [3:0] s, input logic [7:0] a,
                                          input logic [7:0] b, input logic [TAG_W-1:0] t);
    int sum, prod;
    sum  = int'(a) + int'(b);
    prod = int'(a) * int'(b);
    case (s)
      4'd0: return {8'(sum % 256), (sum > 255), 1'b0, t};
      4'd1: return {8'((int'(a) - int'(b) + 256) % 256), 1'b0, 1'b0, t};
      4'd2: return {8'(prod % 256), 1'b0, 1'b0, t};
      4'd3: return (b == 0) ? {8'hFF, 1'b0, 1'b1, t} : {8'(int'(a) / int'(b)), 1'b0, 1'b0, t};
      default: return {alu_fn(s, a, b), 1'b0, 1'b1, t};
    endcase
  endfunction

  logic [13:0] exp_q[$];
  logic        held = 1'b0;
  logic [13:0] held_val;

  // Scoreboard: values seen at the falling edge are what the next rising edge acts on.
  always @(negedge clock) begin
    if (!reset_n) begin
      exp_q.delete();
      held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_valid", rsp_valid, 1);
        chk("hold_stable", {rsp_data, rsp_carry, rsp_err, rsp_tag}, held_val);
      end
      if (cmd_valid && cmd_ready) exp_q.push_back(ref_rsp(cmd_sel, cmd_a, cmd_b, cmd_tag));
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
        else chk("rsp_order", {rsp_data, rsp_carry, rsp_err, rsp_tag}, exp_q.pop_front());
      end
      held     = rsp_valid && !rsp_ready;
      held_val = {rsp_data, rsp_carry, rsp_err, rsp_tag};
    end
  end

  task automatic push_cmd(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b,
                          input logic [TAG_W-1:0] t);
    int n = 0;
    cmd_valid = 1'b1; cmd_sel = s; cmd_a = a; cmd_b = b; cmd_tag = t;
    do begin
      @(negedge clock);
      n++;
    end while (!cmd_ready && n < 200);
    if (!cmd_ready) chk("push_timeout", cmd_ready, 1);
    @(posedge clock); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_one(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b,
                         input logic [TAG_W-1:0] t, input logic [7:0] ed,
                         input logic ec, input logic ee);
    push_cmd(s, a, b, t);
    chk("lat_count_push", count, 1);
    @(posedge clock); #1;
    chk("lat_valid_n1", rsp_valid, 0);
    chk("lat_count_pop", count, 0);
    chk("issue_a", alu_a, a);
    chk("issue_b", alu_b, b);
    chk("issue_sel", alu_sel, s);
    @(posedge clock); #1;
    chk("lat_valid_n2", rsp_valid, 0);
    @(posedge clock); #1;
    chk("lat_valid_n3", rsp_valid, 1);
    chk("rsp_data", rsp_data, ed);
    chk("rsp_carry", rsp_carry, ec);
    chk("rsp_err", rsp_err, ee);
    chk("rsp_tag", rsp_tag, t);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < 1000) begin
      @(posedge clock);
      n++;
    end
    #1;
    chk("drain_done", exp_q.size(), 0);
  endtask

  logic accepted;
  int   vcount;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk("rst_count", count, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_alu", {alu_a, alu_b, alu_sel}, 0);
    chk("rst_rsp", {rsp_data, rsp_carry, rsp_err, rsp_tag}, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b1;

    // Directed operations
    run_one(4'b0000, 8'hF0, 8'h20, 4'd3, 8'h10, 1'b1, 1'b0);
    run_one(4'b0011, 8'h40, 8'h00, 4'd5, 8'hFF, 1'b0, 1'b1);
    run_one(4'b0011, 8'h40, 8'h08, 4'd6, 8'h08, 1'b0, 1'b0);
    run_one(4'b0111, 8'h59, 8'hC0, 4'd9, 8'hAC, 1'b0, 1'b1);
    run_one(4'b0001, 8'hF0, 8'h20, 4'hA, 8'hD0, 1'b0, 1'b0);
    @(posedge clock); #1;

    // Back-pressure: response slot held, FIFO fills up
    rsp_ready = 1'b0;
    push_cmd(4'b0000, 8'h01, 8'h02, 4'd1);
    push_cmd(4'b0010, 8'h10, 8'h20, 4'd2);
    push_cmd(4'b0001, 8'h05, 8'h09, 4'd3);
    push_cmd(4'b0011, 8'h80, 8'h04, 4'd4);
    push_cmd(4'b1010, 8'h3C, 8'h0F, 4'd5);
    cmd_valid = 1'b1; cmd_sel = 4'b0000; cmd_a = 8'hFF; cmd_b = 8'hFF; cmd_tag = 4'd6;
    repeat (4) begin
      @(negedge clock);
      chk("full_cmd_ready", cmd_ready, 0);
      chk("full_count", count, 4);
      chk("full_rsp_valid", rsp_valid, 1);
    end
    @(posedge clock); #1;
    rsp_ready = 1'b1;
    push_cmd(4'b0000, 8'hFF, 8'hFF, 4'd6);
    wait_drain();

    // Randomized traffic
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clock);
      accepted = cmd_valid && cmd_ready;
      @(posedge clock); #1;
      if (!cmd_valid || accepted) begin
        if ($urandom_range(0, 2) != 0) begin
          cmd_valid = 1'b1;
          cmd_sel   = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
          cmd_a     = 8'($urandom);
          cmd_b     = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
          cmd_tag   = 4'($urandom);
        end else begin
          cmd_valid = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_drain();

    // Reset during EXEC with two commands queued
    rsp_ready = 1'b0;
    push_cmd(4'b0000, 8'h11, 8'h22, 4'd6);
    repeat (3) @(posedge clock);
    #1;
    chk("rst_pre_held", rsp_valid, 1);
    push_cmd(4'b0001, 8'h33, 8'h11, 4'd7);
    push_cmd(4'b0010, 8'h03, 8'h04, 4'd8);
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_sel = 4'b0000; cmd_a = 8'h44; cmd_b = 8'h55; cmd_tag = 4'd9;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    chk("rst_pre_count", count, 2);
    chk("rst_pre_alu_a", alu_a, 8'h33);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_valid", rsp_valid, 0);
    chk("rst_mid_count", count, 0);
    chk("rst_mid_ready", cmd_ready, 1);
    chk("rst_mid_alu", {alu_a, alu_b, alu_sel}, 0);
    chk("rst_mid_rsp", {rsp_data, rsp_carry, rsp_err, rsp_tag}, 0);
    @(negedge clock);
    @(posedge clock); #2;
    reset_n = 1'b1;
    vcount = 0;
    repeat (20) begin
      @(negedge clock);
      if (rsp_valid || count != 0) vcount++;
    end
    chk("no_stale_rsp", vcount, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
